// File: rtl/sal_bk_ctrl.sv
// Per-bank controller: buffers one request, tracks the row state and raises
// act/rd/wr/pre/ref requests toward the scheduler once intra-bank timing is met.
module sal_bk_ctrl #(
    parameter int unsigned BK_ID = 0,
    parameter int unsigned BA_W  = 3,
    parameter int unsigned RA_W  = 14,
    parameter int unsigned CA_W  = 10,
    parameter int unsigned ID_W  = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned SEQ_W = 8,
    parameter int unsigned TW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // timing monitor
    input  logic [TW-1:0]    t_rc_m1_i,
    input  logic [TW-1:0]    t_rcd_m1_i,
    input  logic [TW-1:0]    t_rp_m1_i,
    input  logic [TW-1:0]    t_ras_m1_i,
    input  logic [TW-1:0]    t_rfc_m1_i,
    input  logic [TW-1:0]    t_rtp_m1_i,
    input  logic [TW-1:0]    t_wtp_m1_i,
    input  logic [TW-1:0]    row_open_cnt_i,
    // request destination
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_wr_i,
    input  logic [ID_W-1:0]  req_id_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [SEQ_W-1:0] req_seq_num_i,
    input  logic [RA_W-1:0]  req_ra_i,
    input  logic [CA_W-1:0]  req_ca_i,
    // refresh handshake
    input  logic             ref_req_i,
    output logic             ref_ack_o,
    // request to scheduler
    output logic             bk_act_req_o,
    output logic             bk_rd_req_o,
    output logic             bk_wr_req_o,
    output logic             bk_pre_req_o,
    output logic             bk_ref_req_o,
    output logic [BA_W-1:0]  bk_ba_o,
    output logic [RA_W-1:0]  bk_ra_o,
    output logic [CA_W-1:0]  bk_ca_o,
    output logic [SEQ_W-1:0] bk_seq_num_o,
    output logic [ID_W-1:0]  bk_id_o,
    output logic [LEN_W-1:0] bk_len_o,
    // grant from scheduler
    input  logic             bk_act_gnt_i,
    input  logic             bk_rd_gnt_i,
    input  logic             bk_wr_gnt_i,
    input  logic             bk_pre_gnt_i,
    input  logic             bk_ref_gnt_i
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPEN    = 2'd1,
        REFRESH = 2'd2
    } state_t;

    state_t             state_q;
    logic               ref_q;
    logic               buf_valid_q;
    logic               buf_wr_q;
    logic [ID_W-1:0]    buf_id_q;
    logic [LEN_W-1:0]   buf_len_q;
    logic [SEQ_W-1:0]   buf_seq_q;
    logic [RA_W-1:0]    buf_ra_q;
    logic [CA_W-1:0]    buf_ca_q;
    logic [RA_W-1:0]    open_row_q;
    logic [TW-1:0]      rc_q, rcd_q, rp_q, ras_q, rfc_q, rtp_q, wtp_q;
    logic [TW-1:0]      idle_q;

    logic rc_met, rcd_met, rp_met, ras_met, rfc_met, rtp_met, wtp_met;
    logic hit, miss, timeout;
    logic act_req, rd_req, wr_req, pre_req, ref_req;
    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;

    // Loads on a grant, otherwise counts down and saturates at zero.
    function automatic logic [TW-1:0] tick(input logic ld, input logic [TW-1:0] m1,
                                           input logic [TW-1:0] cur);
        if (ld) return m1;
        if (cur == '0) return '0;
        return cur - 1'b1;
    endfunction

    always_comb begin
        rc_met  = (rc_q  == '0);
        rcd_met = (rcd_q == '0);
        rp_met  = (rp_q  == '0);
        ras_met = (ras_q == '0);
        rfc_met = (rfc_q == '0);
        rtp_met = (rtp_q == '0);
        wtp_met = (wtp_q == '0);
        hit     = buf_valid_q && (buf_ra_q == open_row_q);
        miss    = buf_valid_q && (buf_ra_q != open_row_q);
        timeout = !buf_valid_q && (idle_q == row_open_cnt_i);

        act_req = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        pre_req = 1'b0;
        ref_req = 1'b0;
        unique case (state_q)
            CLOSED: begin
                if (ref_q) begin
                    ref_req = rp_met && rc_met;
                end else begin
                    act_req = buf_valid_q && rp_met && rc_met && rfc_met;
                end
            end
            OPEN: begin
                // A pending hit blocks the precharge until it has been served.
                if (hit) begin
                    rd_req = rcd_met && !buf_wr_q;
                    wr_req = rcd_met && buf_wr_q;
                end else begin
                    pre_req = (miss || ref_q || timeout) && ras_met && rtp_met && wtp_met;
                end
            end
            default: ;
        endcase
    end

    assign act_fire = act_req && bk_act_gnt_i;
    assign rd_fire  = rd_req  && bk_rd_gnt_i;
    assign wr_fire  = wr_req  && bk_wr_gnt_i;
    assign pre_fire = pre_req && bk_pre_gnt_i;
    assign ref_fire = ref_req && bk_ref_gnt_i;

    assign bk_act_req_o = act_req;
    assign bk_rd_req_o  = rd_req;
    assign bk_wr_req_o  = wr_req;
    assign bk_pre_req_o = pre_req;
    assign bk_ref_req_o = ref_req;
    assign bk_ba_o      = rst_n ? BA_W'(BK_ID) : '0;
    assign bk_ra_o      = act_req ? buf_ra_q : open_row_q;
    assign bk_ca_o      = buf_ca_q;
    assign bk_seq_num_o = buf_seq_q;
    assign bk_id_o      = buf_id_q;
    assign bk_len_o     = buf_len_q;
    assign ref_ack_o    = ref_fire;
    assign req_ready_o  = rst_n && !buf_valid_q && !ref_req_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLOSED;
            ref_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_id_q    <= '0;
            buf_len_q   <= '0;
            buf_seq_q   <= '0;
            buf_ra_q    <= '0;
            buf_ca_q    <= '0;
            open_row_q  <= '0;
            rc_q        <= '0;
            rcd_q       <= '0;
            rp_q        <= '0;
            ras_q       <= '0;
            rfc_q       <= '0;
            rtp_q       <= '0;
            wtp_q       <= '0;
            idle_q      <= '0;
        end else begin
            // Masking with the ack keeps a slow-dropping source from re-arming refresh.
            ref_q <= ref_req_i && !ref_fire;

            if (rd_fire || wr_fire) begin
                buf_valid_q <= 1'b0;
            end else if (req_valid_i && req_ready_o) begin
                buf_valid_q <= 1'b1;
                buf_wr_q    <= req_wr_i;
                buf_id_q    <= req_id_i;
                buf_len_q   <= req_len_i;
                buf_seq_q   <= req_seq_num_i;
                buf_ra_q    <= req_ra_i;
                buf_ca_q    <= req_ca_i;
            end

            rc_q  <= tick(act_fire || ref_fire, t_rc_m1_i, rc_q);
            rcd_q <= tick(act_fire, t_rcd_m1_i, rcd_q);
            ras_q <= tick(act_fire, t_ras_m1_i, ras_q);
            rp_q  <= tick(pre_fire, t_rp_m1_i, rp_q);
            rfc_q <= tick(ref_fire, t_rfc_m1_i, rfc_q);
            rtp_q <= tick(rd_fire, t_rtp_m1_i, rtp_q);
            wtp_q <= tick(wr_fire, t_wtp_m1_i, wtp_q);

            if (act_fire || rd_fire || wr_fire) begin
                idle_q <= '0;
            end else if (state_q == OPEN && !buf_valid_q && idle_q < row_open_cnt_i) begin
                idle_q <= idle_q + 1'b1;
            end

            unique case (state_q)
                CLOSED: begin
                    if (ref_fire) begin
                        state_q <= REFRESH;
                    end else if (act_fire) begin
                        state_q    <= OPEN;
                        open_row_q <= buf_ra_q;
                    end
                end
                OPEN: begin
                    if (pre_fire) state_q <= CLOSED;
                end
                REFRESH: begin
                    if (rfc_met) state_q <= CLOSED;
                end
                default: state_q <= CLOSED;
            endcase
        end
    end

    // Grants without their request bit are dropped by the fire gating above.
    a_act_gnt: assert property (@(posedge clk) disable iff (!rst_n) bk_act_gnt_i |-> act_req);
    a_rd_gnt:  assert property (@(posedge clk) disable iff (!rst_n) bk_rd_gnt_i  |-> rd_req);
    a_wr_gnt:  assert property (@(posedge clk) disable iff (!rst_n) bk_wr_gnt_i  |-> wr_req);
    a_pre_gnt: assert property (@(posedge clk) disable iff (!rst_n) bk_pre_gnt_i |-> pre_req);
    a_ref_gnt: assert property (@(posedge clk) disable iff (!rst_n) bk_ref_gnt_i |-> ref_req);
    a_onehot:  assert property (@(posedge clk) disable iff (!rst_n)
                   $onehot0({act_req, rd_req, wr_req, pre_req, ref_req}));

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Directed bench for sal_bk_ctrl; a same-cycle scheduler grants every raised request.
module tb_sal_bk_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1, row_open_cnt;
    logic        req_valid, req_ready, req_wr;
    logic [3:0]  req_id, req_len;
    logic [7:0]  req_seq;
    logic [13:0] req_ra;
    logic [9:0]  req_ca;
    logic        ref_req_i, ref_ack;
    logic        act_req, rd_req, wr_req, pre_req, ref_req;
    logic [2:0]  ba;
    logic [13:0] ra;
    logic [9:0]  ca;
    logic [7:0]  seq;
    logic [3:0]  id, len;
    logic        gnt_en;
    logic        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act_gnt = gnt_en & act_req;
    assign rd_gnt  = gnt_en & rd_req;
    assign wr_gnt  = gnt_en & wr_req;
    assign pre_gnt = gnt_en & pre_req;
    assign ref_gnt = gnt_en & ref_req;

    sal_bk_ctrl #(.BK_ID(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rc_m1_i(t_rc_m1), .t_rcd_m1_i(t_rcd_m1), .t_rp_m1_i(t_rp_m1), .t_ras_m1_i(t_ras_m1),
        .t_rfc_m1_i(t_rfc_m1), .t_rtp_m1_i(t_rtp_m1), .t_wtp_m1_i(t_wtp_m1),
        .row_open_cnt_i(row_open_cnt),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr), .req_id_i(req_id),
        .req_len_i(req_len), .req_seq_num_i(req_seq), .req_ra_i(req_ra), .req_ca_i(req_ca),
        .ref_req_i(ref_req_i), .ref_ack_o(ref_ack),
        .bk_act_req_o(act_req), .bk_rd_req_o(rd_req), .bk_wr_req_o(wr_req),
        .bk_pre_req_o(pre_req), .bk_ref_req_o(ref_req),
        .bk_ba_o(ba), .bk_ra_o(ra), .bk_ca_o(ca), .bk_seq_num_o(seq), .bk_id_o(id), .bk_len_o(len),
        .bk_act_gnt_i(act_gnt), .bk_rd_gnt_i(rd_gnt), .bk_wr_gnt_i(wr_gnt),
        .bk_pre_gnt_i(pre_gnt), .bk_ref_gnt_i(ref_gnt)
    );

    // Event log of granted commands, sampled mid-cycle.
    int n_act = 0, n_rd = 0, n_wr = 0, n_pre = 0, n_ref = 0, n_ack = 0, n_rdy_bad = 0;
    int t_act = 0, t_act_p = 0, t_rd = 0, t_rd_p = 0, t_wr = 0, t_pre = 0, t_pre_p = 0;
    int t_ref = 0, t_ack = 0;
    logic [13:0] act_ra = '0, pre_ra = '0;
    logic [9:0]  rd_ca = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt_en && act_req) begin n_act++; t_act_p = t_act; t_act = cyc; act_ra = ra; end
            if (gnt_en && rd_req)  begin n_rd++;  t_rd_p = t_rd;   t_rd = cyc;  rd_ca = ca;  end
            if (gnt_en && wr_req)  begin n_wr++;  t_wr = cyc; end
            if (gnt_en && pre_req) begin n_pre++; t_pre_p = t_pre; t_pre = cyc; pre_ra = ra; end
            if (gnt_en && ref_req) begin n_ref++; t_ref = cyc; end
            if (ref_ack) begin n_ack++; t_ack = cyc; end
            if (ref_req_i && req_ready) n_rdy_bad++;
        end
    end

    task automatic send(input logic wr, input logic [13:0] r, input logic [9:0] c,
                        input logic [3:0] i_id, input logic [3:0] l, input logic [7:0] s);
        bit ok;
        req_valid = 1'b1; req_wr = wr; req_ra = r; req_ca = c;
        req_id = i_id; req_len = l; req_seq = s;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout ready=0 required=1 ra=%0d", r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gnt_en = 1'b1; ref_req_i = 1'b0; req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({act_req, rd_req, wr_req, pre_req, ref_req, ref_ack, req_ready, ba, ra, ca, seq, id, len} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {act_req, rd_req, wr_req, pre_req, ref_req, ref_ack, req_ready, ba, ra, ca, seq, id, len});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b required=1", req_ready); end
        checks++;
        if (ba !== 3'd2) begin failures++; $display("FAIL ba got=%0d required=2", ba); end
        checks++;
        if ({act_req, rd_req, wr_req, pre_req, ref_req} !== 5'b0) begin
            failures++; $display("FAIL idle_reqs got=%b required=00000", {act_req, rd_req, wr_req, pre_req, ref_req});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_single();
        int a0 = n_act, r0 = n_rd, w0 = n_wr, p0 = n_pre;
        send(1'b0, 14'd5, 10'd8, 4'd1, 4'd2, 8'd10);
        repeat (40) @(posedge clk); #1;
        checks++; if (n_act - a0 != 1) begin failures++; $display("FAIL t1_act_count got=%0d required=1", n_act - a0); end
        checks++; if (act_ra !== 14'd5) begin failures++; $display("FAIL t1_act_ra got=%0d required=5", act_ra); end
        checks++; if (n_rd - r0 != 1 || n_wr - w0 != 0) begin failures++; $display("FAIL t1_rd_count got=%0d/%0d required=1/0", n_rd - r0, n_wr - w0); end
        checks++; if (t_rd - t_act != 4) begin failures++; $display("FAIL t1_act_to_rd got=%0d required=4", t_rd - t_act); end
        checks++; if (rd_ca !== 10'd8) begin failures++; $display("FAIL t1_rd_ca got=%0d required=8", rd_ca); end
        checks++; if (n_pre - p0 != 1) begin failures++; $display("FAIL t1_pre_count got=%0d required=1", n_pre - p0); end
        checks++; if (t_pre - t_act != 9) begin failures++; $display("FAIL t1_act_to_pre got=%0d required=9", t_pre - t_act); end
        checks++; if (pre_ra !== 14'd5) begin failures++; $display("FAIL t1_pre_ra got=%0d required=5", pre_ra); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL t1_ready_end got=%b required=1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int a0 = n_act, r0 = n_rd, w0 = n_wr, p0 = n_pre;
        send(1'b1, 14'd5, 10'd1, 4'd3, 4'd1, 8'd20);
        send(1'b0, 14'd5, 10'd2, 4'd4, 4'd1, 8'd21);
        repeat (40) @(posedge clk); #1;
        checks++; if (n_act - a0 != 1) begin failures++; $display("FAIL t2_act_count got=%0d required=1", n_act - a0); end
        checks++; if (n_wr - w0 != 1 || n_rd - r0 != 1) begin failures++; $display("FAIL t2_wr_rd_count got=%0d/%0d required=1/1", n_wr - w0, n_rd - r0); end
        checks++; if (t_wr - t_act != 4) begin failures++; $display("FAIL t2_act_to_wr got=%0d required=4", t_wr - t_act); end
        checks++; if (t_rd - t_wr != 2) begin failures++; $display("FAIL t2_wr_to_rd got=%0d required=2", t_rd - t_wr); end
        checks++; if (rd_ca !== 10'd2) begin failures++; $display("FAIL t2_rd_ca got=%0d required=2", rd_ca); end
        checks++; if (n_pre - p0 != 1) begin failures++; $display("FAIL t2_pre_count got=%0d required=1", n_pre - p0); end
        checks++; if (t_pre - t_rd != 5) begin failures++; $display("FAIL t2_rd_to_pre got=%0d required=5", t_pre - t_rd); end
    endtask

    task automatic test_row_miss();
        int a0 = n_act, r0 = n_rd, p0 = n_pre;
        send(1'b0, 14'd5, 10'd3, 4'd5, 4'd1, 8'd30);
        send(1'b0, 14'd9, 10'd4, 4'd6, 4'd1, 8'd31);
        repeat (40) @(posedge clk); #1;
        checks++; if (n_act - a0 != 2) begin failures++; $display("FAIL t3_act_count got=%0d required=2", n_act - a0); end
        checks++; if (n_pre - p0 != 2 || n_rd - r0 != 2) begin failures++; $display("FAIL t3_pre_rd_count got=%0d/%0d required=2/2", n_pre - p0, n_rd - r0); end
        checks++; if (t_pre_p - t_act_p != 8) begin failures++; $display("FAIL t3_act_to_pre got=%0d required=8", t_pre_p - t_act_p); end
        checks++; if (t_act - t_pre_p != 3) begin failures++; $display("FAIL t3_pre_to_act got=%0d required=3", t_act - t_pre_p); end
        checks++; if (t_act - t_act_p != 11) begin failures++; $display("FAIL t3_act_to_act got=%0d required=11", t_act - t_act_p); end
        checks++; if (act_ra !== 14'd9) begin failures++; $display("FAIL t3_act_ra got=%0d required=9", act_ra); end
        checks++; if (t_rd - t_act != 4 || rd_ca !== 10'd4) begin failures++; $display("FAIL t3_second_rd got=%0d/%0d required=4/4", t_rd - t_act, rd_ca); end
    endtask

    task automatic test_refresh();
        int a0 = n_act, f0 = n_ref, k0 = n_ack, b0 = n_rdy_bad;
        bit got;
        send(1'b0, 14'd5, 10'd6, 4'd1, 4'd1, 8'd40);
        ref_req_i = 1'b1;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ref_ack) begin got = 1; break; end
        end
        @(posedge clk); #1 ref_req_i = 1'b0;
        checks++; if (!got) begin failures++; $display("FAIL t4_ack_timeout got=0 required=1"); end
        send(1'b0, 14'd7, 10'd1, 4'd1, 4'd1, 8'd41);
        repeat (45) @(posedge clk); #1;
        checks++; if (n_ack - k0 != 1 || t_ack != t_ref) begin failures++; $display("FAIL t4_ack_pulse got=%0d@%0d required=1@%0d", n_ack - k0, t_ack, t_ref); end
        checks++; if (n_ref - f0 != 1) begin failures++; $display("FAIL t4_ref_count got=%0d required=1", n_ref - f0); end
        checks++; if (t_pre_p - t_rd_p != 4) begin failures++; $display("FAIL t4_hit_then_pre got=%0d required=4", t_pre_p - t_rd_p); end
        checks++; if (t_ref - t_pre_p != 3) begin failures++; $display("FAIL t4_pre_to_ref got=%0d required=3", t_ref - t_pre_p); end
        checks++; if (t_act - t_ref < 16 || t_act - t_ref > 17) begin failures++; $display("FAIL t4_ref_to_act got=%0d required=16..17", t_act - t_ref); end
        checks++; if (n_act - a0 != 2 || act_ra !== 14'd7) begin failures++; $display("FAIL t4_act got=%0d ra=%0d required=2 ra=7", n_act - a0, act_ra); end
        checks++; if (n_rdy_bad - b0 != 0) begin failures++; $display("FAIL t4_ready_during_ref got=%0d required=0", n_rdy_bad - b0); end
    endtask

    task automatic test_grant_hold_reset();
        int a0 = n_act;
        gnt_en = 1'b0;
        send(1'b0, 14'd3, 10'd5, 4'd2, 4'd1, 8'd9);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({act_req, ra, ca, seq, id, len} !== {1'b1, 14'd3, 10'd5, 8'd9, 4'd2, 4'd1}) begin
                failures++;
                $display("FAIL t5_hold cyc=%0d got=%h required=%h", i, {act_req, ra, ca, seq, id, len},
                         {1'b1, 14'd3, 10'd5, 8'd9, 4'd2, 4'd1});
            end
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({act_req, rd_req, wr_req, pre_req, ref_req, ref_ack, req_ready, ba, ra, ca, seq, id, len} !== '0) begin
            failures++;
            $display("FAIL t5_abort_outputs got=%h required=0",
                     {act_req, rd_req, wr_req, pre_req, ref_req, ref_ack, req_ready, ba, ra, ca, seq, id, len});
        end
        rst_n = 1'b1; gnt_en = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++; if (n_act - a0 != 0) begin failures++; $display("FAIL t5_buffer_lost got=%0d required=0", n_act - a0); end
    endtask

    task automatic test_closed_page();
        int w0 = n_wr, p0 = n_pre;
        row_open_cnt = 8'd0;
        send(1'b1, 14'd2, 10'd7, 4'd1, 4'd1, 8'd50);
        repeat (30) @(posedge clk); #1;
        checks++; if (n_wr - w0 != 1 || t_wr - t_act != 4) begin failures++; $display("FAIL t6_wr got=%0d@+%0d required=1@+4", n_wr - w0, t_wr - t_act); end
        checks++; if (n_pre - p0 != 1) begin failures++; $display("FAIL t6_pre_count got=%0d required=1", n_pre - p0); end
        checks++; if (t_pre - t_wr != 5) begin failures++; $display("FAIL t6_wr_to_pre got=%0d required=5", t_pre - t_wr); end
        row_open_cnt = 8'd4;
    endtask

    initial begin
        rst_n = 1'b0; gnt_en = 1'b1; ref_req_i = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_id = '0; req_len = '0; req_seq = '0; req_ra = '0; req_ca = '0;
        t_rcd_m1 = 8'd3; t_rp_m1 = 8'd2; t_ras_m1 = 8'd7; t_rc_m1 = 8'd10;
        t_rfc_m1 = 8'd15; t_rtp_m1 = 8'd1; t_wtp_m1 = 8'd4; row_open_cnt = 8'd4;
        test_reset();
        test_rd_single();
        test_back_to_back();
        test_row_miss();
        test_refresh();
        test_grant_hold_reset();
        test_closed_page();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
